// File: rtl/mux2to1_trio_pkg.sv
// mux2to1_trio_pkg: shared style selectors and default width for the mux trio
package mux2to1_trio_pkg;
    localparam int STYLE_COND    = 0;
    localparam int STYLE_IF      = 1;
    localparam int STYLE_CASE    = 2;
    localparam int DEFAULT_WIDTH = 1;
endpackage

// File: rtl/mux2to1_trio_leaf.sv
// mux2to1_leaf: 2:1 mux whose coding style (conditional, if/else, case) is picked at elaboration
module mux2to1_leaf
    import mux2to1_trio_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int STYLE = STYLE_COND
) (
    input  logic [WIDTH-1:0] i_in0,
    input  logic [WIDTH-1:0] i_in1,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_out
);
    if (STYLE == STYLE_COND) begin : g_cond
        assign o_out = i_sel ? i_in1 : i_in0;
    end else if (STYLE == STYLE_IF) begin : g_if
        always_comb begin
            if (i_sel) o_out = i_in1;
            else       o_out = i_in0;
        end
    end else begin : g_case
        // An unknown select falls to the default arm and drives in0
        always_comb begin
            case (i_sel)
                1'b0:    o_out = i_in0;
                1'b1:    o_out = i_in1;
                default: o_out = i_in0;
            endcase
        end
    end
endmodule

// File: rtl/mux2to1_trio.sv
// mux2to1_trio: three independently coded 2:1 muxes, their registered copies,
// and a registered flag raised whenever the three disagree
module mux2to1_trio
    import mux2to1_trio_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             se1,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out1_q,
    output logic [WIDTH-1:0] out2_q,
    output logic [WIDTH-1:0] out3_q,
    output logic             mismatch_q
);
    logic [WIDTH-1:0] r_out1_q, r_out2_q, r_out3_q;
    logic             r_mismatch_q;
    logic             w_mismatch;

    mux2to1_leaf #(.WIDTH(WIDTH), .STYLE(STYLE_COND)) u_cond (
        .i_in0(in0), .i_in1(in1), .i_sel(se1), .o_out(out1)
    );
    mux2to1_leaf #(.WIDTH(WIDTH), .STYLE(STYLE_IF)) u_if (
        .i_in0(in0), .i_in1(in1), .i_sel(se1), .o_out(out2)
    );
    mux2to1_leaf #(.WIDTH(WIDTH), .STYLE(STYLE_CASE)) u_case (
        .i_in0(in0), .i_in1(in1), .i_sel(se1), .o_out(out3)
    );

    assign w_mismatch = (out1 != out2) | (out1 != out3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out1_q     <= '0;
            r_out2_q     <= '0;
            r_out3_q     <= '0;
            r_mismatch_q <= 1'b0;
        end else begin
            r_out1_q     <= out1;
            r_out2_q     <= out2;
            r_out3_q     <= out3;
            r_mismatch_q <= w_mismatch;
        end
    end

    assign out1_q     = r_out1_q;
    assign out2_q     = r_out2_q;
    assign out3_q     = r_out3_q;
    assign mismatch_q = r_mismatch_q;
endmodule

// File: tb/tb_mux2to1_trio.sv
// tb_mux2to1_trio: directed and random checks of the mux trio at WIDTH=1 and WIDTH=8
module tb_mux2to1_trio;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_in0 = 1'b0, a_in1 = 1'b0, a_se1 = 1'b0;
    logic       a_o1, a_o2, a_o3, a_q1, a_q2, a_q3, a_mm;
    logic [7:0] b_in0 = 8'h00, b_in1 = 8'h00;
    logic       b_se1 = 1'b0;
    logic [7:0] b_o1, b_o2, b_o3, b_q1, b_q2, b_q3;
    logic       b_mm;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] sb1[$];
    logic [7:0] sb8[$];

    always #5 clk = ~clk;

    mux2to1_trio #(.WIDTH(1)) u_a (
        .clk(clk), .rst(rst), .in0(a_in0), .in1(a_in1), .se1(a_se1),
        .out1(a_o1), .out2(a_o2), .out3(a_o3),
        .out1_q(a_q1), .out2_q(a_q2), .out3_q(a_q3), .mismatch_q(a_mm)
    );

    mux2to1_trio #(.WIDTH(8)) u_b (
        .clk(clk), .rst(rst), .in0(b_in0), .in1(b_in1), .se1(b_se1),
        .out1(b_o1), .out2(b_o2), .out3(b_o3),
        .out1_q(b_q1), .out2_q(b_q2), .out3_q(b_q3), .mismatch_q(b_mm)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_a_comb(input string tag, input logic exp);
        chk({tag, ".out1"}, {7'd0, a_o1}, {7'd0, exp});
        chk({tag, ".out2"}, {7'd0, a_o2}, {7'd0, exp});
        chk({tag, ".out3"}, {7'd0, a_o3}, {7'd0, exp});
    endtask

    task automatic chk_a_q(input string tag, input logic exp, input logic exp_mm);
        chk({tag, ".out1_q"}, {7'd0, a_q1}, {7'd0, exp});
        chk({tag, ".out2_q"}, {7'd0, a_q2}, {7'd0, exp});
        chk({tag, ".out3_q"}, {7'd0, a_q3}, {7'd0, exp});
        chk({tag, ".mismatch_q"}, {7'd0, a_mm}, {7'd0, exp_mm});
    endtask

    task automatic chk_b_comb(input string tag, input logic [7:0] exp);
        chk({tag, ".out1"}, b_o1, exp);
        chk({tag, ".out2"}, b_o2, exp);
        chk({tag, ".out3"}, b_o3, exp);
    endtask

    task automatic pop_a(input string tag);
        logic [7:0] e;
        if (sb1.size() == 0) begin
            tests++; fails++;
            $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
        end else begin
            e = sb1.pop_front();
            chk_a_q(tag, e[0], 1'b0);
        end
    endtask

    task automatic pop_b(input string tag);
        logic [7:0] e;
        if (sb8.size() == 0) begin
            tests++; fails++;
            $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
        end else begin
            e = sb8.pop_front();
            chk({tag, ".out1_q"}, b_q1, e);
            chk({tag, ".out2_q"}, b_q2, e);
            chk({tag, ".out3_q"}, b_q3, e);
            chk({tag, ".mismatch_q"}, {7'd0, b_mm}, 8'h00);
        end
    endtask

    initial begin
        logic [7:0] tt_exp;
        logic [2:0] v;
        tt_exp = 8'b1101_1000;
        #12;
        chk_a_q("reset_a", 1'b0, 1'b0);
        chk({"reset_b", ".out1_q"}, b_q1, 8'h00);
        chk({"reset_b", ".mismatch_q"}, {7'd0, b_mm}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            {a_in0, a_in1, a_se1} = v;
            #50;
            chk_a_comb($sformatf("tt%0d", i), tt_exp[i]);
        end
        @(negedge clk) rst = 1'b0;
        {a_in0, a_in1, a_se1} = 3'b011;
        sb1.push_back(8'd1);
        @(posedge clk) #1;
        pop_a("reg_011");
        @(negedge clk) {a_in0, a_in1, a_se1} = 3'b101;
        #1;
        chk_a_comb("comb_101", 1'b0);
        chk_a_q("hold_101", 1'b1, 1'b0);
        sb1.push_back(8'd0);
        @(posedge clk) #1;
        pop_a("reg_101");
        @(negedge clk) {a_in0, a_in1, a_se1} = 3'b011;
        sb1.push_back(8'd1);
        @(posedge clk) #1;
        pop_a("reg_011b");
        #2 rst = 1'b1;
        #1;
        chk_a_q("async_rst", 1'b0, 1'b0);
        {a_in0, a_in1, a_se1} = 3'b100;
        #1;
        chk_a_comb("comb_in_rst", 1'b1);
        chk_a_q("still_rst", 1'b0, 1'b0);
        @(negedge clk) {a_in0, a_in1, a_se1} = 3'b110;
        rst = 1'b0;
        #1;
        chk_a_q("rel_hold", 1'b0, 1'b0);
        sb1.push_back(8'd1);
        @(posedge clk) #1;
        pop_a("rel_first");
        @(negedge clk) begin b_in0 = 8'hA5; b_in1 = 8'h3C; b_se1 = 1'b0; end
        #1;
        chk_b_comb("wide_s0", 8'hA5);
        sb8.push_back(8'hA5);
        @(posedge clk) #1;
        pop_b("wide_s0");
        @(negedge clk) b_se1 = 1'b1;
        #1;
        chk_b_comb("wide_s1", 8'h3C);
        sb8.push_back(8'h3C);
        @(posedge clk) #1;
        pop_b("wide_s1");
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] e;
            @(negedge clk);
            b_in0 = 8'($urandom);
            b_in1 = 8'($urandom);
            b_se1 = 1'($urandom);
            e = b_se1 ? b_in1 : b_in0;
            #1;
            chk_b_comb($sformatf("rnd%0d", i), e);
            sb8.push_back(e);
            @(posedge clk) #1;
            pop_b($sformatf("rnd%0d", i));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
